// File: rtl/fp_normalizer.sv
// rtl/fp_normalizer.sv - two-stage left normalizer with exponent adjust; FP_NORM_DENORM_EN selects gradual underflow
module fp_normalizer #(
   parameter int WIDTH     = 56,
   parameter int WIDTH_LOG = 6,
   parameter int EXP_W     = 11
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_mant,
   input  logic [WIDTH_LOG-1:0] in_msb,
   input  logic [EXP_W-1:0]     in_exp,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_mant,
   output logic [EXP_W-1:0]     out_exp,
   output logic                 out_zero,
   output logic                 out_uflow,
   output logic [15:0]          uflow_cnt
);

   localparam logic [WIDTH_LOG-1:0] MSB_TOP = WIDTH_LOG'(WIDTH - 1);

   logic                 w_en;

   logic                 r_s1_valid;
   logic [WIDTH-1:0]     r_s1_mant;
   logic [EXP_W-1:0]     r_s1_exp;
   logic [WIDTH_LOG-1:0] r_s1_sh;
   logic                 r_s1_zero;

   logic                 r_out_valid;
   logic [WIDTH-1:0]     r_out_mant;
   logic [EXP_W-1:0]     r_out_exp;
   logic                 r_out_zero;
   logic                 r_out_uflow;
   logic [15:0]          r_uflow_cnt;

   logic [EXP_W:0]       w_exp_x;
   logic [EXP_W:0]       w_sh_x;
   logic [WIDTH-1:0]     w_mant;
   logic [EXP_W-1:0]     w_exp;
   logic                 w_zero;
   logic                 w_uflow;
`ifdef FP_NORM_DENORM_EN
   logic [EXP_W:0]       w_eff_sh;
`endif

   // Both stages advance together; a held output freezes the whole pipe.
   assign w_en     = !r_out_valid || out_ready;
   assign in_ready = w_en;

   // Stage 1: capture the beat, derive the shift and our own zero flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_mant  <= '0;
         r_s1_exp   <= '0;
         r_s1_sh    <= '0;
         r_s1_zero  <= 1'b0;
      end else if (w_en) begin
         r_s1_valid <= in_valid;
         r_s1_mant  <= in_mant;
         r_s1_exp   <= in_exp;
         r_s1_sh    <= MSB_TOP - in_msb;
         r_s1_zero  <= (in_mant == '0);
      end
   end

   // Stage 2 datapath: shift, exponent reduction, zero/underflow handling.
   always_comb begin
      w_exp_x = {1'b0, r_s1_exp};
      w_sh_x  = (EXP_W + 1)'(r_s1_sh);
      w_mant  = '0;
      w_exp   = '0;
      w_zero  = 1'b0;
      w_uflow = 1'b0;
`ifdef FP_NORM_DENORM_EN
      w_eff_sh = '0;
`endif
      if (r_s1_zero) begin
         w_zero = 1'b1;
      end else if (w_exp_x > w_sh_x) begin
         w_mant = r_s1_mant << r_s1_sh;
         w_exp  = EXP_W'(w_exp_x - w_sh_x);
      end else begin
         w_uflow = 1'b1;
`ifdef FP_NORM_DENORM_EN
         // Denormal result: shift only as far as the exponent allows.
         w_eff_sh = (w_exp_x == '0) ? '0 : (w_exp_x - {{EXP_W{1'b0}}, 1'b1});
         w_mant   = r_s1_mant << w_eff_sh;
`else
         w_zero = 1'b1;
`endif
      end
   end

   // Stage 2 registers: load the result whenever the pipe advances.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_mant  <= '0;
         r_out_exp   <= '0;
         r_out_zero  <= 1'b0;
         r_out_uflow <= 1'b0;
      end else if (w_en) begin
         r_out_valid <= r_s1_valid;
         r_out_mant  <= w_mant;
         r_out_exp   <= w_exp;
         r_out_zero  <= w_zero;
         r_out_uflow <= w_uflow;
      end
   end

   // Saturating count of valid underflow beats entering the output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_uflow_cnt <= '0;
      end else if (w_en && r_s1_valid && w_uflow && (r_uflow_cnt != 16'hFFFF)) begin
         r_uflow_cnt <= r_uflow_cnt + 16'd1;
      end
   end

   assign out_valid = r_out_valid;
   assign out_mant  = r_out_mant;
   assign out_exp   = r_out_exp;
   assign out_zero  = r_out_zero;
   assign out_uflow = r_out_uflow;
   assign uflow_cnt = r_uflow_cnt;

endmodule

// File: doc/fp_normalizer.md
# fp_normalizer

Two-stage pipelined left-normalizer that sits directly downstream of the priority encoder in the floating-point subtract/add datapath. It takes the raw difference mantissa, the encoder's leading-one index and the pre-normalization biased exponent. It shifts the mantissa so its leading one lands in bit WIDTH-1 and reduces the exponent by the shift amount. It handles zero results and exponent underflow, and exerts valid/ready flow control toward the rounding stage.

## Interface
- WIDTH, 56, mantissa width; must match the encoder's WIDTH
- WIDTH_LOG, 6, bits of leading-one index; 2^WIDTH_LOG >= WIDTH
- EXP_W, 11, biased exponent width
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts the beat this cycle
- in_mant  in  WIDTH  un-normalized mantissa (encoder's diff input)
- in_msb  in  WIDTH_LOG  encoder's leading-one index for in_mant; ignored when in_mant==0
- in_exp  in  EXP_W  biased exponent before normalization
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- out_mant  out  WIDTH  normalized mantissa
- out_exp  out  EXP_W  adjusted biased exponent
- out_zero  out  1  result is exact zero
- out_uflow  out  1  exponent underflowed during normalization
- uflow_cnt  out  16  saturating count of accepted beats that set out_uflow

## Operation
- Pipeline enable: en = !out_valid || out_ready. in_ready = en. in_ready depends only on registered state and out_ready, never on in_valid.
- Stage 1 (on en): registers s1_valid = in_valid, plus mantissa, exponent and sh = (WIDTH-1) - in_msb (WIDTH_LOG bits, unsigned).
- Stage 1 also computes the zero flag: z = (in_mant == 0). The block derives this itself and does not trust in_msb for it.
- Stage 2 (on en): computes the result from the stage 1 registers and loads the output registers; out_valid takes s1_valid.
- Stage 2 rules for z=1: out_mant=0, out_exp=0, out_zero=1, out_uflow=0.
- Stage 2 rules for z=0 and exp > sh: out_mant = mant << sh, out_exp = exp - sh, out_zero=0, out_uflow=0.
- Stage 2 rules for z=0 and exp <= sh: underflow, handled as described under Configuration.
- Exponent arithmetic is done in EXP_W+1 bits. sh is zero-extended before compare and subtract.
- uflow_cnt increments when a beat with out_uflow=1 loads into the output registers. It saturates at 16'hFFFF and does not wrap.
- Bubbles (s1_valid=0) propagate as out_valid=0. Data fields of a bubble are don't-care, but the uflow_cnt increment is gated by valid.

## Timing
- Latency is 2 cycles: a beat accepted at edge N appears on out_* after edge N+1 and is visible until consumed. Throughput is 1 beat/cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, both stages freeze and in_ready=0. out_* stays stable, with no data change while valid is held.
- Simultaneous events: out_ready=1 with in_valid=1 on the same edge transfers one beat out and one beat in.
- Reset, including mid-stream: on any clk edge with rst=1, all in-flight beats are discarded.
- Reset values: out_valid=0, s1_valid=0, out_mant=0, out_exp=0, out_zero=0, out_uflow=0, uflow_cnt=0.
- in_ready is 1 in the cycle after reset deasserts.

## Configuration
- Macro FP_NORM_DENORM_EN controls gradual underflow.
- Defined (underflow case): effective shift = (exp==0) ? 0 : exp-1. out_mant = mant << effective shift, out_exp=0, out_zero=0, out_uflow=1.
- Undefined (flush-to-zero underflow case): out_mant=0, out_exp=0, out_zero=1, out_uflow=1.
- Both builds update uflow_cnt identically.

## Test plan
- Normal case (WIDTH=56): in_mant=1<<50, in_msb=50, in_exp=100 -> 2 cycles later out_mant=1<<55, out_exp=95, out_zero=0, out_uflow=0.
- Zero: in_mant=0, in_msb=17 (garbage), in_exp=300 -> out_mant=0, out_exp=0, out_zero=1, out_uflow=0, uflow_cnt unchanged.
- Underflow: in_mant=1<<40, in_msb=40, in_exp=10 (sh=15).
  - With FP_NORM_DENORM_EN -> out_mant=1<<49, out_exp=0, out_uflow=1.
  - Without it -> out_mant=0, out_zero=1, out_uflow=1.
  - Either build -> uflow_cnt=1.
- Backpressure: send 3 back-to-back beats with out_ready=0 for 4 cycles -> in_ready=0 from the first stall cycle, out_* frozen on beat 1. Raise out_ready -> beats 1,2,3 emerge in order on consecutive cycles with no loss or duplication.
- Sweep: feed the all-ones-shifted mantissa sequence (55..0 leading zeros) with matching encoder indices and in_exp=200 at full rate -> every out_mant has bit 55 set (except the all-zero beat) and out_exp = 200 - (55 - msb).
- Reset mid-operation: assert rst for 1 cycle with 2 beats in flight -> the next cycle shows out_valid=0, uflow_cnt=0, in_ready=1, and no stale beat emerges afterward.
